// File: rtl/dnn_pkg.sv
// Shared DNN grid definitions: default geometry and the feeder FSM states.
package dnn_pkg;

    localparam int unsigned DNN_DATA_WIDTH = 8;
    localparam int unsigned DNN_ROW_NUM    = 8;
    localparam int unsigned DNN_COL_NUM    = 8;

    typedef enum logic [2:0] {
        LOAD     = 3'd0,
        WAIT_NN  = 3'd1,
        SEND     = 3'd2,
        WAIT_RES = 3'd3,
        RESULT   = 3'd4
    } feeder_state_t;

endpackage : dnn_pkg

// File: rtl/dnn_grid_buffer.sv
// ROW_NUM x COL_NUM pixel store: raster-index write, whole-column read.
module dnn_grid_buffer
    import dnn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DNN_DATA_WIDTH,
    parameter int unsigned ROW_NUM    = DNN_ROW_NUM,
    parameter int unsigned COL_NUM    = DNN_COL_NUM,
    parameter int unsigned PIX_W      = $clog2(ROW_NUM * COL_NUM),
    parameter int unsigned COL_W      = $clog2(COL_NUM)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [PIX_W-1:0]      wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [COL_W-1:0]      rd_col,
    output logic [DATA_WIDTH-1:0] rd_data [ROW_NUM]
);

    logic [DATA_WIDTH-1:0] mem [ROW_NUM][COL_NUM];

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        for (int r = 0; r < int'(ROW_NUM); r++) begin
            for (int c = 0; c < int'(COL_NUM); c++) begin
                if (wr_en && (wr_idx == PIX_W'(r * int'(COL_NUM) + c))) begin
                    mem[r][c] <= wr_data;
                end
            end
        end
    end

    always_comb begin
        for (int r = 0; r < int'(ROW_NUM); r++) begin
            rd_data[r] = mem[r][rd_col];
        end
    end

endmodule : dnn_grid_buffer

// File: rtl/dnn_grid_feeder.sv
// Buffers one raster-order 8x8 grid, bursts it column-wise into the DNN and
// returns the DNN's classification result over a valid/ready handshake.
module dnn_grid_feeder
    import dnn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DNN_DATA_WIDTH,
    parameter int unsigned ROW_NUM    = DNN_ROW_NUM,
    parameter int unsigned COL_NUM    = DNN_COL_NUM
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pixel_iv,
    input  logic [DATA_WIDTH-1:0] pixel_id,
    output logic                  pixel_or,
    output logic                  grid_ov,
    output logic [DATA_WIDTH-1:0] row_od [ROW_NUM],
    input  logic                  nn_occupied_i,
    input  logic                  nn_result_iv,
    input  logic [DATA_WIDTH-1:0] nn_result_id,
    output logic                  result_ov,
    output logic [DATA_WIDTH-1:0] result_od,
    input  logic                  result_ir,
    output logic                  busy_o
);

    localparam int unsigned PIX_W = $clog2(ROW_NUM * COL_NUM);
    localparam int unsigned COL_W = $clog2(COL_NUM);
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(ROW_NUM * COL_NUM - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COL_NUM - 1);

    feeder_state_t         state;
    logic [PIX_W-1:0]      pix_cnt;
    logic [COL_W-1:0]      col_cnt;
    logic [COL_W-1:0]      rd_col;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] col_data [ROW_NUM];

    // Ready is held low during reset even though the reset state is LOAD.
    assign pixel_or = (state == LOAD) && !rst;
    assign busy_o   = (state != LOAD);
    assign wr_en    = pixel_iv && pixel_or;
    // Read one column ahead so row_od can be registered with no bubble.
    assign rd_col   = (state == SEND) ? col_cnt + COL_W'(1) : '0;

    dnn_grid_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .ROW_NUM    (ROW_NUM),
        .COL_NUM    (COL_NUM),
        .PIX_W      (PIX_W),
        .COL_W      (COL_W)
    ) u_buffer (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_idx  (pix_cnt),
        .wr_data (pixel_id),
        .rd_col  (rd_col),
        .rd_data (col_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LOAD;
            pix_cnt   <= '0;
            col_cnt   <= '0;
            grid_ov   <= 1'b0;
            result_ov <= 1'b0;
            result_od <= '0;
            for (int r = 0; r < int'(ROW_NUM); r++) begin
                row_od[r] <= '0;
            end
        end else begin
            case (state)
                LOAD: begin
                    if (pixel_iv) begin
                        if (pix_cnt == LAST_PIX) begin
                            pix_cnt <= '0;
                            state   <= WAIT_NN;
                        end else begin
                            pix_cnt <= pix_cnt + PIX_W'(1);
                        end
                    end
                end
                WAIT_NN: begin
                    if (!nn_occupied_i) begin
                        state   <= SEND;
                        grid_ov <= 1'b1;
                        col_cnt <= '0;
                        row_od  <= col_data;
                    end
                end
                // Burst runs to completion regardless of nn_occupied_i.
                SEND: begin
                    if (col_cnt == LAST_COL) begin
                        state   <= WAIT_RES;
                        grid_ov <= 1'b0;
                        col_cnt <= '0;
                        for (int r = 0; r < int'(ROW_NUM); r++) begin
                            row_od[r] <= '0;
                        end
                    end else begin
                        col_cnt <= col_cnt + COL_W'(1);
                        row_od  <= col_data;
                    end
                end
                WAIT_RES: begin
                    if (nn_result_iv) begin
                        state     <= RESULT;
                        result_ov <= 1'b1;
                        result_od <= nn_result_id;
                    end
                end
                RESULT: begin
                    if (result_ir) begin
                        state     <= LOAD;
                        result_ov <= 1'b0;
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule : dnn_grid_feeder

// File: doc/dnn_grid_feeder.md
# dnn_grid_feeder

Producer side of the DNN grid interface. Accepts an 8×8 image as a raster-order pixel stream over a valid/ready handshake and buffers the full grid. When the DNN is not occupied, it drives the grid into the DNN one column per cycle. It then captures the DNN's single classification result and hands it upstream over a second valid/ready handshake. One grid is in flight at a time.

## Interface
- DATA_WIDTH, 8, width of each pixel and of the result
- ROW_NUM, 8, grid rows; equals the number of lanes in `row_od`
- COL_NUM, 8, grid columns; equals the burst length in cycles
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous and active-high
- pixel_iv  in  1  upstream pixel valid
- pixel_id  in  DATA_WIDTH  pixel value, raster order (row-major, r0c0 first)
- pixel_or  out  1  feeder ready for a pixel
- grid_ov  out  1  column valid; connects to the DNN `input_grid_iv`
- row_od  out  DATA_WIDTH × ROW_NUM (unpacked)  column data; lane r = grid[r][c]; connects to the DNN `row_input_id`
- nn_occupied_i  in  1  DNN busy flag
- nn_result_iv  in  1  DNN result valid (DNN `output_ov`)
- nn_result_id  in  DATA_WIDTH  DNN result (DNN `output_od`)
- result_ov  out  1  result valid to upstream
- result_od  out  DATA_WIDTH  captured result
- result_ir  in  1  upstream accepts the result
- busy_o  out  1  high in every state except LOAD

## Operation
- States: LOAD, WAIT_NN, SEND, WAIT_RES, RESULT. Reset state is LOAD.
- **LOAD**
  - `pixel_or` = 1.
  - Handshake (`pixel_iv` & `pixel_or`) writes grid[k / COL_NUM][k % COL_NUM]; pixel counter k increments.
  - The handshake with k = ROW_NUM·COL_NUM−1 moves to WAIT_NN and clears k.
- **WAIT_NN**
  - `pixel_or` = 0.
  - On the first edge that samples `nn_occupied_i` = 0, move to SEND, set `grid_ov` = 1 and load column 0 onto `row_od`.
- **SEND**
  - `grid_ov` stays 1 for exactly COL_NUM consecutive cycles, one per column index c = 0..COL_NUM−1.
  - `nn_occupied_i` is ignored during the burst; the burst is never stalled.
  - After column COL_NUM−1: `grid_ov` drops to 0, `row_od` drops to 0, move to WAIT_RES.
- **WAIT_RES**
  - On `nn_result_iv`, register `nn_result_id` into `result_od`, set `result_ov`, move to RESULT.
- **RESULT**
  - `result_ov` and `result_od` are held until `result_ir` = 1.
  - On that edge, `result_ov` drops and the FSM returns to LOAD.
- `nn_result_iv` in any state other than WAIT_RES is ignored and `result_od` is unchanged.
- Pixels are not accepted during WAIT_NN, SEND, WAIT_RES or RESULT.
- Counters:
  - pixel counter is `$clog2(ROW_NUM*COL_NUM)` bits
  - column counter is `$clog2(COL_NUM)` bits
  - both saturate-free; they are cleared on state exit
- No arithmetic is performed on data; the pixel path is bit-exact.

## Timing
- Reset values:
  - `pixel_or` = 0 while `rst` is asserted; it goes to 1 in the first cycle after release, since it is decoded from LOAD.
  - `grid_ov`, `result_ov`, `busy_o` = 0.
  - `row_od` lanes = 0; `result_od` = 0.
  - counters = 0.
  - grid buffer contents are not reset (don't care).
- `grid_ov`, `row_od`, `result_ov`, `result_od` are registered. `pixel_or` and `busy_o` decode from state.
- Latency, for a last pixel accepted at edge T with `nn_occupied_i` low:
  - column c is valid in cycle T+1+c
  - `grid_ov` falls after cycle T+COL_NUM
- If `nn_occupied_i` is high, the burst start slips one cycle per cycle of occupancy. There is no timeout.
- Result: `result_ov` rises the cycle after `nn_result_iv`. When `result_ir` is already high, it is held for exactly one cycle.
- `nn_result_iv` and `result_ir` arriving in the same cycle: the capture happens first, and the handshake completes on the next edge.
- `rst` asserted mid-burst or mid-load:
  - outputs drop immediately (asynchronous)
  - the partial grid is discarded
  - the FSM restarts in LOAD with k = 0

## Structure
- Shared package `dnn_pkg`:
  - state enum `feeder_state_t`
  - default DATA_WIDTH / ROW_NUM / COL_NUM localparams, shared with the DNN
- One sub-module, `dnn_grid_buffer`: a ROW_NUM×COL_NUM register array with raster-index write and column-index read of all rows. The FSM, counters and handshakes stay in `dnn_grid_feeder`.

## Test plan
- Pixels 0..63 streamed back-to-back with `nn_occupied_i` = 0:
  - `grid_ov` is high for exactly 8 cycles
  - cycle c shows `row_od[r]` = 8r+c, e.g. c=0 gives {0,8,..,56}
  - `busy_o` rises after pixel 63
- `nn_occupied_i` held high for 5 cycles after load: `grid_ov` first rises on the edge after occupancy drops, and `pixel_or` stays 0 throughout.
- `pixel_iv` toggled randomly with gaps: grid content is identical to the gap-free case, and pixel 64 is not accepted (`pixel_or` = 0).
- `nn_result_iv` with 0x2A while `result_ir` = 0 for 3 cycles:
  - `result_od` = 0x2A is held with `result_ov` = 1
  - a stray `nn_result_iv` of 0x11 during RESULT does not change it
  - the handshake returns the FSM to LOAD
- `rst` pulsed during column 4 of the burst:
  - `grid_ov` = 0 immediately
  - the next 64 pixels form a fresh grid, verified as in the first scenario
